fp_trace_writer: RTL and testbench

FP_TRACE_WRITER -- requirements
Module: fp_trace_writer

---
 rtl/fp_trace_writer_pkg.sv | 67 ++++++
 rtl/fp_trace_fifo.sv | 59 +++++
 rtl/fp_trace_writer.sv | 104 ++++++++++
 tb/tb_fp_trace_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_trace_writer_pkg.sv
// Shared types, record field positions and error indices for the fp trace writer.
// The NaN canonicalisation helper is used only when FP_TRACE_NAN_CANON_EN is defined.
package fp_wire;

    localparam int unsigned REC_W      = 288;
    localparam int unsigned DATA1_LSB  = 224;
    localparam int unsigned DATA2_LSB  = 160;
    localparam int unsigned DATA3_LSB  = 96;
    localparam int unsigned RESULT_LSB = 32;
    localparam int unsigned FLAGS_LSB  = 24;
    localparam int unsigned FMT_LSB    = 20;
    localparam int unsigned RM_LSB     = 16;
    localparam int unsigned OP_LSB     = 12;
    localparam int unsigned OPCODE_LSB = 0;

    localparam int unsigned ERR_OVERFLOW = 0;
    localparam int unsigned ERR_ORPHAN   = 1;
    localparam int unsigned ERR_OVERRUN  = 2;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opcode;
    } fp_trace_entry_type;

    function automatic logic [REC_W-1:0] pack_record(input fp_trace_entry_type e,
                                                     input logic [63:0] result,
                                                     input logic [4:0] flags);
        logic [REC_W-1:0] rec_s;
        rec_s = {REC_W{1'b0}};
        rec_s[DATA1_LSB  +: 64] = e.data1;
        rec_s[DATA2_LSB  +: 64] = e.data2;
        rec_s[DATA3_LSB  +: 64] = e.data3;
        rec_s[RESULT_LSB +: 64] = result;
        rec_s[FLAGS_LSB  +: 5]  = flags;
        rec_s[FMT_LSB    +: 2]  = e.fmt;
        rec_s[RM_LSB     +: 3]  = e.rm;
        rec_s[OP_LSB     +: 2]  = e.op;
        rec_s[OPCODE_LSB +: 10] = e.opcode;
        return rec_s;
    endfunction

    // Compares and float-to-int conversions return integers, so they are never rewritten.
    function automatic logic [63:0] canon_nan(input logic [63:0] result,
                                              input logic [1:0] fmt,
                                              input logic [9:0] opcode);
        logic [63:0] res_s;
        res_s = result;
        if (!opcode[6] && !opcode[9]) begin
            if (fmt == 2'd0 && (&result[30:23]) && (|result[22:0])) begin
                res_s = 64'h0000_0000_7FC0_0000;
            end else if (fmt == 2'd1 && (&result[62:52]) && (|result[51:0])) begin
                res_s = 64'h7FF8_0000_0000_0000;
            end else begin
                res_s = result;
            end
        end else begin
            res_s = result;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/fp_trace_fifo.sv
// In-order queue of issued operations awaiting completion.
module fp_trace_fifo
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  fp_trace_entry_type push_entry,
    output fp_trace_entry_type head_entry,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fp_trace_entry_type mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic               push_s;
    logic               pop_s;

    // Guard the enables so a misuse by the parent can never corrupt the count.
    always_comb begin
        full       = (count_r == (AW+1)'(DEPTH));
        empty      = (count_r == (AW+1)'(0));
        pop_s      = pop && !empty;
        push_s     = push && (!full || pop_s);
        head_entry = mem_r[rd_ptr_r];
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_trace_writer.sv
// Pairs fp_unit issues with completions in order and emits 288-bit trace records.
// Optional macro FP_TRACE_NAN_CANON_EN canonicalises NaN results in the record.
module fp_trace_writer
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [63:0]        issue_data1,
    input  logic [63:0]        issue_data2,
    input  logic [63:0]        issue_data3,
    input  logic [1:0]         issue_fmt,
    input  logic [2:0]         issue_rm,
    input  logic [1:0]         issue_op,
    input  logic [9:0]         issue_opcode,
    input  logic               done_ready,
    input  logic [63:0]        done_result,
    input  logic [4:0]         done_flags,
    output logic               rec_valid,
    output logic [REC_W-1:0]   rec_data,
    input  logic               rec_ready,
    output logic               full,
    output logic [2:0]         err
);

    fp_trace_entry_type issue_entry_s;
    fp_trace_entry_type head_entry_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic               stalled_s;
    logic [2:0]         err_set_s;
    logic [63:0]        result_s;
    logic [REC_W-1:0]   record_s;
    logic               rec_valid_r;
    logic [REC_W-1:0]   rec_data_r;
    logic [2:0]         err_r;

    fp_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (issue_entry_s),
        .head_entry (head_entry_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Queue control, error detection and next-record assembly.
    always_comb begin
        issue_entry_s.data1  = issue_data1;
        issue_entry_s.data2  = issue_data2;
        issue_entry_s.data3  = issue_data3;
        issue_entry_s.fmt    = issue_fmt;
        issue_entry_s.rm     = issue_rm;
        issue_entry_s.op     = issue_op;
        issue_entry_s.opcode = issue_opcode;

        pop_s     = done_ready && !fifo_empty_s;
        push_s    = issue_valid && (!fifo_full_s || pop_s);
        stalled_s = rec_valid_r && !rec_ready;

        err_set_s               = 3'b000;
        err_set_s[ERR_OVERFLOW] = issue_valid && fifo_full_s && !pop_s;
        err_set_s[ERR_ORPHAN]   = done_ready && fifo_empty_s;
        err_set_s[ERR_OVERRUN]  = pop_s && stalled_s;

`ifdef FP_TRACE_NAN_CANON_EN
        result_s = canon_nan(done_result, head_entry_s.fmt, head_entry_s.opcode);
`else
        result_s = done_result;
`endif
        record_s = pack_record(head_entry_s, result_s, done_flags);
    end

    // Output record register; a stalled record is never overwritten.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rec_valid_r <= 1'b0;
            rec_data_r  <= {REC_W{1'b0}};
            err_r       <= 3'b000;
        end else begin
            if (pop_s && !stalled_s) begin
                rec_valid_r <= 1'b1;
                rec_data_r  <= record_s;
            end else if (rec_valid_r && rec_ready) begin
                rec_valid_r <= 1'b0;
            end else begin
                rec_valid_r <= rec_valid_r;
            end
            err_r <= err_r | err_set_s;
        end
    end

    assign rec_valid = rec_valid_r;
    assign rec_data  = rec_data_r;
    assign err       = err_r;
    assign full      = fifo_full_s;

endmodule

// File: tb/tb_fp_trace_writer.sv
// Self-checking bench for fp_trace_writer: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_fp_trace_writer;

    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         issue_valid;
    logic [63:0]  issue_data1, issue_data2, issue_data3;
    logic [1:0]   issue_fmt;
    logic [2:0]   issue_rm;
    logic [1:0]   issue_op;
    logic [9:0]   issue_opcode;
    logic         done_ready;
    logic [63:0]  done_result;
    logic [4:0]   done_flags;
    logic         rec_valid;
    logic [287:0] rec_data;
    logic         rec_ready;
    logic         full;
    logic [2:0]   err;

    fp_trace_writer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_data1(issue_data1), .issue_data2(issue_data2),
        .issue_data3(issue_data3), .issue_fmt(issue_fmt), .issue_rm(issue_rm),
        .issue_op(issue_op), .issue_opcode(issue_opcode),
        .done_ready(done_ready), .done_result(done_result), .done_flags(done_flags),
        .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
        .full(full), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d1, d2, d3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opc;
    } op_t;

    typedef struct {
        bit         iv;
        bit         dr;
        bit         exp_rv;
        bit         exp_full;
        logic [2:0] exp_err;
        int         exp_op;
    } vec_t;

    int checks = 0;
    int errors = 0;

    op_t          m_q[$];
    bit           m_rv;
    logic [287:0] m_rd;
    logic [2:0]   m_err;

    function automatic logic [287:0] exp_rec(op_t o, logic [63:0] r, logic [4:0] f);
        return {o.d1, o.d2, o.d3, r, 3'b000, f, 2'b00, o.fmt, 1'b0, o.rm, 2'b00, o.op, 2'b00, o.opc};
    endfunction

    function automatic logic [63:0] ref_result(op_t o, logic [63:0] r);
`ifdef FP_TRACE_NAN_CANON_EN
        if (o.opc[6] == 1'b0 && o.opc[9] == 1'b0) begin
            if (o.fmt == 2'd0 && r[30:23] == 8'hFF && r[22:0] != 23'd0) return 64'h0000_0000_7FC0_0000;
            if (o.fmt == 2'd1 && r[62:52] == 11'h7FF && r[51:0] != 52'd0) return 64'h7FF8_0000_0000_0000;
        end
`endif
        return r;
    endfunction

    function automatic op_t mk_op(int k);
        op_t o;
        o.d1  = {32'hA1A1_0000, 32'(k)};
        o.d2  = {32'hB2B2_0000, 32'(k)};
        o.d3  = {32'hC3C3_0000, 32'(k)};
        o.fmt = 2'(k);
        o.rm  = 3'(k);
        o.op  = 2'(k + 1);
        o.opc = 10'(1 << (k % 10));
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.d1  = {$urandom, $urandom};
        o.d2  = {$urandom, $urandom};
        o.d3  = {$urandom, $urandom};
        o.fmt = 2'($urandom_range(0, 1));
        o.rm  = 3'($urandom);
        o.op  = 2'($urandom);
        o.opc = 10'(1 << $urandom_range(0, 9));
        return o;
    endfunction

    task automatic chk(string name, logic [287:0] act, logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending operations and one output slot.
    task automatic model(bit rst, bit iv, op_t o, bit dr, logic [63:0] res, logic [4:0] fl, bit rr);
        int  n;
        bit  popped;
        op_t h;
        if (rst) begin
            m_q.delete();
            m_rv  = 1'b0;
            m_rd  = '0;
            m_err = 3'b000;
            return;
        end
        n      = m_q.size();
        popped = dr && (n > 0);
        if (dr && n == 0) m_err[1] = 1'b1;
        if (popped) begin
            h = m_q.pop_front();
            if (m_rv && !rr) begin
                m_err[2] = 1'b1;
            end else begin
                m_rv = 1'b1;
                m_rd = exp_rec(h, ref_result(h, res), fl);
            end
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
        if (iv) begin
            if (n == DEPTH && !popped) m_err[0] = 1'b1;
            else m_q.push_back(o);
        end
    endtask

    task automatic step(bit rst, bit iv, op_t o, bit dr, logic [63:0] res, logic [4:0] fl, bit rr, string tag);
        reset        = !rst;
        issue_valid  = iv;
        issue_data1  = o.d1;
        issue_data2  = o.d2;
        issue_data3  = o.d3;
        issue_fmt    = o.fmt;
        issue_rm     = o.rm;
        issue_op     = o.op;
        issue_opcode = o.opc;
        done_ready   = dr;
        done_result  = res;
        done_flags   = fl;
        rec_ready    = rr;
        @(posedge clock);
        model(rst, iv, o, dr, res, fl, rr);
        @(negedge clock);
        chk({tag, ".rec_valid"}, 288'(rec_valid), 288'(m_rv));
        chk({tag, ".rec_data"}, rec_data, m_rd);
        chk({tag, ".full"}, 288'(full), 288'(m_q.size() == DEPTH));
        chk({tag, ".err"}, 288'(err), 288'(m_err));
    endtask

    function automatic logic [63:0] tbl_res(int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    vec_t tbl[11];
    op_t  nop;
    op_t  a, b, c;

    initial begin
        nop = mk_op(0);
        m_rv = 1'b0; m_rd = '0; m_err = 3'b000;
        @(negedge clock);

        // Reset state
        step(1, 0, nop, 0, 64'd0, 5'd0, 0, "rst");
        step(1, 1, nop, 1, 64'd5, 5'd1, 1, "rst2");
        chk("reset_rec_valid", 288'(rec_valid), 288'(0));
        chk("reset_rec_data", rec_data, 288'(0));
        chk("reset_err", 288'(err), 288'(0));
        chk("reset_full", 288'(full), 288'(0));

        // Fill, overflow, push+pop at full, drain in order
        tbl[0]  = '{1, 0, 0, 0, 3'b000, -1};
        tbl[1]  = '{1, 0, 0, 0, 3'b000, -1};
        tbl[2]  = '{1, 0, 0, 0, 3'b000, -1};
        tbl[3]  = '{1, 0, 0, 1, 3'b000, -1};
        tbl[4]  = '{1, 0, 0, 1, 3'b001, -1};
        tbl[5]  = '{1, 1, 1, 1, 3'b001, 0};
        tbl[6]  = '{0, 1, 1, 0, 3'b001, 1};
        tbl[7]  = '{0, 1, 1, 0, 3'b001, 2};
        tbl[8]  = '{0, 1, 1, 0, 3'b001, 3};
        tbl[9]  = '{0, 1, 1, 0, 3'b001, 5};
        tbl[10] = '{0, 0, 0, 0, 3'b001, -1};
        step(1, 0, nop, 0, 64'd0, 5'd0, 1, "tbl_rst");
        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].iv, mk_op(i), tbl[i].dr, tbl_res(i), 5'(i), 1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_rv", i), 288'(rec_valid), 288'(tbl[i].exp_rv));
            chk($sformatf("tbl%0d_full", i), 288'(full), 288'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_err", i), 288'(err), 288'(tbl[i].exp_err));
            if (tbl[i].exp_op >= 0)
                chk($sformatf("tbl%0d_rec", i), rec_data,
                    exp_rec(mk_op(tbl[i].exp_op), tbl_res(i), 5'(i)));
        end

        // Orphan completion after reset
        step(1, 0, nop, 0, 64'd0, 5'd0, 1, "orph_rst");
        step(0, 0, nop, 1, 64'd7, 5'd3, 1, "orph");
        chk("orphan_err", 288'(err), 288'(3'b010));
        chk("orphan_rv", 288'(rec_valid), 288'(0));

        // fadd 1.0 + 2.0 = 3.0 in double precision
        step(1, 0, nop, 0, 64'd0, 5'd0, 1, "fadd_rst");
        a = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 2'd1, 3'd0, 2'd0, 10'b00_0000_0010};
        step(0, 1, a, 0, 64'd0, 5'd0, 1, "fadd_iss");
        chk("fadd_rv_before", 288'(rec_valid), 288'(0));
        step(0, 0, nop, 1, 64'h4008_0000_0000_0000, 5'd0, 0, "fadd_done");
        chk("fadd_rv", 288'(rec_valid), 288'(1));
        chk("fadd_result", 288'(rec_data[95:32]), 288'(64'h4008_0000_0000_0000));
        chk("fadd_opc_bit1", 288'(rec_data[1]), 288'(1));

        // Two completions while the sink stalls
        step(1, 0, nop, 0, 64'd0, 5'd0, 1, "ovr_rst");
        a = mk_op(21); b = mk_op(22); c = mk_op(23);
        step(0, 1, a, 0, 64'd0, 5'd0, 0, "ovr_a");
        step(0, 1, b, 0, 64'd0, 5'd0, 0, "ovr_b");
        step(0, 1, c, 0, 64'd0, 5'd0, 0, "ovr_c");
        step(0, 0, nop, 1, 64'd111, 5'd1, 0, "ovr_d1");
        step(0, 0, nop, 1, 64'd222, 5'd2, 0, "ovr_d2");
        chk("ovr_held", rec_data, exp_rec(a, 64'd111, 5'd1));
        chk("ovr_err", 288'(err[2]), 288'(1));
        step(0, 0, nop, 1, 64'd333, 5'd3, 1, "ovr_d3");
        chk("ovr_third_is_c", rec_data, exp_rec(c, 64'd333, 5'd3));
        chk("ovr_rv_stays", 288'(rec_valid), 288'(1));
        step(0, 0, nop, 1, 64'd444, 5'd4, 1, "ovr_empty");
        chk("ovr_now_empty", 288'(err[1]), 288'(1));
        chk("ovr_rv_clear", 288'(rec_valid), 288'(0));

        // fsqrt single-precision NaN result
        step(1, 0, nop, 0, 64'd0, 5'd0, 1, "nan_rst");
        a = '{64'd4, 64'd0, 64'd0, 2'd0, 3'd1, 2'd0, 10'b00_0010_0000};
        step(0, 1, a, 0, 64'd0, 5'd0, 1, "nan_iss");
        step(0, 0, nop, 1, 64'h0000_0000_7FC0_0001, 5'h10, 1, "nan_done");
`ifdef FP_TRACE_NAN_CANON_EN
        chk("nan_result", 288'(rec_data[95:32]), 288'(64'h0000_0000_7FC0_0000));
`else
        chk("nan_result", 288'(rec_data[95:32]), 288'(64'h0000_0000_7FC0_0001));
`endif

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 600; i++) begin
            logic [63:0] res;
            op_t         o;
            int          sel;
            o   = rand_op();
            sel = $urandom_range(0, 3);
            if (sel == 0)      res = {32'($urandom), 1'b0, 8'hFF, 23'($urandom_range(1, 1000))};
            else if (sel == 1) res = {1'b1, 11'h7FF, 20'($urandom), 32'($urandom_range(0, 5))};
            else               res = {$urandom, $urandom};
            step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, o,
                 $urandom_range(0, 1) == 1, res, 5'($urandom), $urandom_range(0, 3) != 0,
                 $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
